// File: rtl/conv_din_streamer.sv
`default_nettype none
// ============================================================================
// Module   : conv_din_streamer
// Brief    : Fetches activations then weights over a valid/ready read port and
//            streams each word's low half to the conv core, then a terminator.
//            Optional macro DIN_STREAM_CHECKSUM_EN enables the stream checksum.
// Revision : 1.0  initial release
// ============================================================================
module conv_din_streamer #(
  parameter int AW  = 26,
  parameter int DW  = 32,
  parameter int GAP = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [4:0]    cfg_h,
  input  logic [4:0]    cfg_w,
  input  logic [7:0]    cfg_i,
  input  logic [7:0]    cfg_o,
  input  logic [2:0]    cfg_k,
  input  logic [AW-1:0] act_base,
  input  logic [AW-1:0] wgt_base,
  output logic          rvalid,
  input  logic          rready,
  output logic [AW-1:0] raddr,
  input  logic [DW-1:0] rdata,
  output logic          din_valid,
  output logic [15:0]   din_data,
  output logic          busy,
  output logic          done,
  output logic [15:0]   checksum
);

  localparam int                 c_GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CALC = 3'd1,
    S_REQ  = 3'd2,
    S_EMIT = 3'd3,
    S_GAP  = 3'd4,
    S_TERM = 3'd5,
    S_DONE = 3'd6
  } state_t;

  state_t               r_state;
  logic [4:0]           r_cfg_h;
  logic [4:0]           r_cfg_w;
  logic [7:0]           r_cfg_i;
  logic [7:0]           r_cfg_o;
  logic [2:0]           r_cfg_k;
  logic [AW-1:0]        r_act_base;
  logic [AW-1:0]        r_wgt_base;
  logic [17:0]          r_na;
  logic [21:0]          r_nw;
  logic [21:0]          r_n;
  logic                 r_wgt_phase;
  logic [c_GAP_W-1:0]   r_gap;

  logic [17:0]          w_na;
  logic [21:0]          w_nw;
  logic [21:0]          w_n_next;
  logic [21:0]          w_phase_cnt;
  logic [AW-1:0]        w_phase_base;
  logic                 w_hs;
  logic                 w_unused_rdata_hi;

  // Operands are widened before multiplying so the products never truncate.
  assign w_na         = 18'(r_cfg_i) * 18'(r_cfg_h) * 18'(r_cfg_w);
  assign w_nw         = 22'(r_cfg_o) * 22'(r_cfg_i) * 22'(r_cfg_k) * 22'(r_cfg_k);
  assign w_n_next     = r_n + 22'd1;
  assign w_phase_cnt  = r_wgt_phase ? r_nw : 22'(r_na);
  assign w_phase_base = r_wgt_phase ? r_wgt_base : r_act_base;
  assign w_hs         = (r_state == S_REQ) && rready;
  assign w_unused_rdata_hi = ^rdata[DW-1:16];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cfg_h     <= '0;
      r_cfg_w     <= '0;
      r_cfg_i     <= '0;
      r_cfg_o     <= '0;
      r_cfg_k     <= '0;
      r_act_base  <= '0;
      r_wgt_base  <= '0;
      r_na        <= '0;
      r_nw        <= '0;
      r_n         <= '0;
      r_wgt_phase <= 1'b0;
      r_gap       <= '0;
      rvalid      <= 1'b0;
      raddr       <= '0;
      din_valid   <= 1'b0;
      din_data    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cfg_h    <= cfg_h;
            r_cfg_w    <= cfg_w;
            r_cfg_i    <= cfg_i;
            r_cfg_o    <= cfg_o;
            r_cfg_k    <= cfg_k;
            r_act_base <= act_base;
            r_wgt_base <= wgt_base;
            busy       <= 1'b1;
            r_state    <= S_CALC;
          end
        end
        S_CALC: begin
          r_na <= w_na;
          r_nw <= w_nw;
          r_n  <= '0;
          if (w_na != '0) begin
            r_wgt_phase <= 1'b0;
            rvalid      <= 1'b1;
            raddr       <= r_act_base;
            r_state     <= S_REQ;
          end else if (w_nw != '0) begin
            r_wgt_phase <= 1'b1;
            rvalid      <= 1'b1;
            raddr       <= r_wgt_base;
            r_state     <= S_REQ;
          end else begin
            din_valid <= 1'b1;
            din_data  <= '0;
            r_state   <= S_TERM;
          end
        end
        S_REQ: begin
          if (w_hs) begin
            rvalid    <= 1'b0;
            din_valid <= 1'b1;
            din_data  <= rdata[15:0];
            r_state   <= S_EMIT;
          end
        end
        S_EMIT: begin
          din_valid <= 1'b0;
          r_gap     <= '0;
          r_state   <= S_GAP;
        end
        S_GAP: begin
          if (r_gap != c_GAP_LAST) begin
            r_gap <= r_gap + c_GAP_W'(1);
          end else if (w_n_next < w_phase_cnt) begin
            r_n     <= w_n_next;
            rvalid  <= 1'b1;
            raddr   <= w_phase_base + AW'(w_n_next);
            r_state <= S_REQ;
          end else if (!r_wgt_phase && (r_nw != '0)) begin
            r_wgt_phase <= 1'b1;
            r_n         <= '0;
            rvalid      <= 1'b1;
            raddr       <= r_wgt_base;
            r_state     <= S_REQ;
          end else begin
            din_valid <= 1'b1;
            din_data  <= '0;
            r_state   <= S_TERM;
          end
        end
        S_TERM: begin
          din_valid <= 1'b0;
          done      <= 1'b1;
          r_state   <= S_DONE;
        end
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef DIN_STREAM_CHECKSUM_EN
  // Accumulates on the read handshake, so only data words contribute.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      checksum <= '0;
    end else if ((r_state == S_IDLE) && start) begin
      checksum <= '0;
    end else if (w_hs) begin
      checksum <= checksum + rdata[15:0];
    end
  end
`else
  assign checksum = 16'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_conv_din_streamer.sv
`default_nettype none
// Directed bench for conv_din_streamer: hand-computed address/data sequences
// for nominal, stalled, zero-dimension, wrapping and reset-abort streams.
module tb_conv_din_streamer;

  localparam int AW  = 26;
  localparam int DW  = 32;
  localparam int GAP = 5;

`ifdef DIN_STREAM_CHECKSUM_EN
  localparam logic [15:0] c_CS_FULL = 16'h1246;
  localparam logic [15:0] c_CS_ONE  = 16'hFFFF;
`else
  localparam logic [15:0] c_CS_FULL = 16'h0000;
  localparam logic [15:0] c_CS_ONE  = 16'h0000;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [4:0]    cfg_h = '0;
  logic [4:0]    cfg_w = '0;
  logic [7:0]    cfg_i = '0;
  logic [7:0]    cfg_o = '0;
  logic [2:0]    cfg_k = '0;
  logic [AW-1:0] act_base = '0;
  logic [AW-1:0] wgt_base = '0;
  logic          rvalid;
  logic          rready = 1'b0;
  logic [AW-1:0] raddr;
  logic [DW-1:0] rdata;
  logic          din_valid;
  logic [15:0]   din_data;
  logic          busy;
  logic          done;
  logic [15:0]   checksum;
  logic [15:0]   mem_lo;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [AW-1:0] hs_addr[$];
  int            hs_cyc[$];
  logic [15:0]   dv_data[$];
  int            dv_cyc[$];
  int            first_rv_cyc;
  int            done_cyc;
  int            viol;
  int            start_cyc;
  bit            timed_out;

  conv_din_streamer #(.AW(AW), .DW(DW), .GAP(GAP)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_h(cfg_h), .cfg_w(cfg_w), .cfg_i(cfg_i), .cfg_o(cfg_o), .cfg_k(cfg_k),
    .act_base(act_base), .wgt_base(wgt_base),
    .rvalid(rvalid), .rready(rready), .raddr(raddr), .rdata(rdata),
    .din_valid(din_valid), .din_data(din_data),
    .busy(busy), .done(done), .checksum(checksum)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory: a few fixed words, otherwise low half = addr[15:0] ^ 16'h5A00.
  always_comb begin
    mem_lo = raddr[15:0] ^ 16'h5A00;
    case (raddr)
      26'h0000100: mem_lo = 16'hFFFF;
      26'h0000101: mem_lo = 16'h0002;
      26'h0000102: mem_lo = 16'h1234;
      26'h0000103: mem_lo = 16'h0001;
      26'h0000200: mem_lo = 16'h0010;
      default:     ;
    endcase
    rdata = {16'hDEAD, mem_lo};
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic set_cfg(input logic [4:0] h, input logic [4:0] w, input logic [7:0] i,
                         input logic [7:0] o, input logic [2:0] k,
                         input logic [AW-1:0] ab, input logic [AW-1:0] wb);
    cfg_h = h; cfg_w = w; cfg_i = i; cfg_o = o; cfg_k = k;
    act_base = ab; wgt_base = wb;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Records one stream until done; stalls each request for 'stall' cycles.
  task automatic collect(input int stall, input bit start_on_done);
    int stall_cnt;
    bit in_req;
    bit done_seen;
    logic [AW-1:0] prev;
    stall_cnt = 0; in_req = 0; done_seen = 0; prev = '0;
    hs_addr.delete(); hs_cyc.delete(); dv_data.delete(); dv_cyc.delete();
    first_rv_cyc = -1; done_cyc = -1; viol = 0; timed_out = 1;
    for (int c = 0; c < 400; c++) begin
      if (din_valid) begin
        dv_data.push_back(din_data);
        dv_cyc.push_back(cyc);
      end
      if (rvalid) begin
        if (first_rv_cyc < 0) first_rv_cyc = cyc;
        if (in_req && (raddr !== prev)) viol++;
        if (!in_req) begin
          in_req = 1; stall_cnt = stall; prev = raddr;
        end
        if (stall_cnt > 0) begin
          rready = 1'b0; stall_cnt--;
        end else begin
          rready = 1'b1;
          hs_addr.push_back(raddr);
          hs_cyc.push_back(cyc);
          in_req = 0;
        end
      end else begin
        if (in_req) viol++;
        rready = 1'b0;
      end
      if (done) begin
        done_seen = 1; done_cyc = cyc;
        if (start_on_done) start = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
      if (done_seen) begin
        timed_out = 0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({rvalid, raddr, din_valid, din_data, busy, done, checksum} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got rv=%0b ra=%0h dv=%0b dd=%0h busy=%0b done=%0b cs=%0h, expected all 0",
               rvalid, raddr, din_valid, din_data, busy, done, checksum);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({rvalid, busy, din_valid} !== 3'b000) begin
      fails++;
      $display("FAIL reset_idle: got rv=%0b busy=%0b dv=%0b, expected 0 0 0", rvalid, busy, din_valid);
    end
  endtask

  task automatic test_basic();
    logic [AW-1:0] ea[5] = '{26'h100, 26'h101, 26'h102, 26'h103, 26'h200};
    logic [15:0]   ed[6] = '{16'hFFFF, 16'h0002, 16'h1234, 16'h0001, 16'h0010, 16'h0000};
    logic [AW-1:0] ga;
    logic [15:0]   gd;
    int min_sp;
    set_cfg(5'd2, 5'd2, 8'd1, 8'd1, 3'd1, 26'h100, 26'h200);
    do_start();
    tests++;
    if (busy !== 1'b1) begin
      fails++; $display("FAIL basic_busy_after_start: got %0b expected 1", busy);
    end
    collect(0, 1'b0);
    tests++;
    if (timed_out) begin
      fails++; $display("FAIL basic_timeout: got no done expected done");
    end
    tests++;
    if (hs_addr.size() != 5) begin
      fails++; $display("FAIL basic_nreads: got %0d expected 5", hs_addr.size());
    end
    for (int i = 0; i < 5; i++) begin
      ga = (i < hs_addr.size()) ? hs_addr[i] : 'x;
      tests++;
      if (ga !== ea[i]) begin
        fails++; $display("FAIL basic_raddr[%0d]: got %0h expected %0h", i, ga, ea[i]);
      end
    end
    tests++;
    if (dv_data.size() != 6) begin
      fails++; $display("FAIL basic_npulses: got %0d expected 6", dv_data.size());
    end
    for (int i = 0; i < 6; i++) begin
      gd = (i < dv_data.size()) ? dv_data[i] : 'x;
      tests++;
      if (gd !== ed[i]) begin
        fails++; $display("FAIL basic_din[%0d]: got %0h expected %0h", i, gd, ed[i]);
      end
    end
    tests++;
    if (first_rv_cyc - start_cyc != 2) begin
      fails++; $display("FAIL basic_first_raddr_latency: got %0d expected 2", first_rv_cyc - start_cyc);
    end
    tests++;
    if (hs_cyc.size() < 1 || dv_cyc.size() < 1 || dv_cyc[0] - hs_cyc[0] != 1) begin
      fails++; $display("FAIL basic_hs_to_din_latency: got mismatch expected 1 cycle");
    end
    min_sp = 1000;
    for (int i = 1; i < dv_cyc.size(); i++)
      if (dv_cyc[i] - dv_cyc[i-1] < min_sp) min_sp = dv_cyc[i] - dv_cyc[i-1];
    tests++;
    if (min_sp < GAP + 1) begin
      fails++; $display("FAIL basic_pulse_spacing: got %0d expected >= %0d", min_sp, GAP + 1);
    end
    tests++;
    if (dv_cyc.size() < 1 || done_cyc != dv_cyc[dv_cyc.size()-1] + 1) begin
      fails++; $display("FAIL basic_done_after_term: got done at %0d expected term+1", done_cyc);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL basic_busy_after_done: got %0b expected 0", busy);
    end
    tests++;
    if (checksum !== c_CS_FULL) begin
      fails++; $display("FAIL basic_checksum: got %0h expected %0h", checksum, c_CS_FULL);
    end
  endtask

  task automatic test_stall();
    logic [15:0] ed[6] = '{16'hFFFF, 16'h0002, 16'h1234, 16'h0001, 16'h0010, 16'h0000};
    logic [15:0] gd;
    set_cfg(5'd2, 5'd2, 8'd1, 8'd1, 3'd1, 26'h100, 26'h200);
    do_start();
    collect(7, 1'b0);
    tests++;
    if (timed_out || viol != 0) begin
      fails++; $display("FAIL stall_stability: got viol=%0d timeout=%0b expected 0 0", viol, timed_out);
    end
    tests++;
    if (hs_cyc.size() < 1 || hs_cyc[0] - first_rv_cyc != 7) begin
      fails++; $display("FAIL stall_hold_cycles: got %0d expected 7",
                        (hs_cyc.size() > 0) ? hs_cyc[0] - first_rv_cyc : -1);
    end
    tests++;
    if (dv_data.size() != 6) begin
      fails++; $display("FAIL stall_npulses: got %0d expected 6", dv_data.size());
    end
    for (int i = 0; i < 6; i++) begin
      gd = (i < dv_data.size()) ? dv_data[i] : 'x;
      tests++;
      if (gd !== ed[i]) begin
        fails++; $display("FAIL stall_din[%0d]: got %0h expected %0h", i, gd, ed[i]);
      end
    end
    tests++;
    if (checksum !== c_CS_FULL) begin
      fails++; $display("FAIL stall_checksum: got %0h expected %0h", checksum, c_CS_FULL);
    end
  endtask

  task automatic test_zero_dims();
    set_cfg(5'd2, 5'd2, 8'd0, 8'd1, 3'd1, 26'h100, 26'h200);
    do_start();
    collect(0, 1'b0);
    tests++;
    if (timed_out || first_rv_cyc != -1) begin
      fails++; $display("FAIL zero_no_reads: got first_rv=%0d timeout=%0b expected -1 0", first_rv_cyc, timed_out);
    end
    tests++;
    if (dv_data.size() != 1 || dv_data[0] !== 16'h0 || dv_cyc[0] != start_cyc + 2) begin
      fails++; $display("FAIL zero_term_only: got %0d pulses expected 1 terminator at start+2", dv_data.size());
    end
    tests++;
    if (dv_cyc.size() < 1 || done_cyc != dv_cyc[0] + 1) begin
      fails++; $display("FAIL zero_done: got %0d expected term+1", done_cyc);
    end
    set_cfg(5'd1, 5'd1, 8'd1, 8'd1, 3'd0, 26'h100, 26'h200);
    do_start();
    collect(0, 1'b0);
    tests++;
    if (hs_addr.size() != 1 || hs_addr[0] !== 26'h100) begin
      fails++; $display("FAIL k0_reads: got %0d reads expected 1 at 100", hs_addr.size());
    end
    tests++;
    if (dv_data.size() != 2 || dv_data[0] !== 16'hFFFF || dv_data[1] !== 16'h0) begin
      fails++; $display("FAIL k0_pulses: got %0d pulses expected FFFF then 0", dv_data.size());
    end
    tests++;
    if (checksum !== c_CS_ONE) begin
      fails++; $display("FAIL k0_checksum: got %0h expected %0h", checksum, c_CS_ONE);
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] ea[4] = '{26'h3FFFFFE, 26'h3FFFFFF, 26'h0000000, 26'h0000001};
    logic [15:0]   ed[5] = '{16'hA5FE, 16'hA5FF, 16'h5A00, 16'h5A01, 16'h0000};
    logic [AW-1:0] ga;
    logic [15:0]   gd;
    set_cfg(5'd2, 5'd2, 8'd1, 8'd0, 3'd1, 26'h3FFFFFE, 26'h200);
    do_start();
    collect(0, 1'b0);
    tests++;
    if (timed_out || hs_addr.size() != 4) begin
      fails++; $display("FAIL wrap_nreads: got %0d expected 4", hs_addr.size());
    end
    for (int i = 0; i < 4; i++) begin
      ga = (i < hs_addr.size()) ? hs_addr[i] : 'x;
      tests++;
      if (ga !== ea[i]) begin
        fails++; $display("FAIL wrap_raddr[%0d]: got %0h expected %0h", i, ga, ea[i]);
      end
    end
    for (int i = 0; i < 5; i++) begin
      gd = (i < dv_data.size()) ? dv_data[i] : 'x;
      tests++;
      if (gd !== ed[i]) begin
        fails++; $display("FAIL wrap_din[%0d]: got %0h expected %0h", i, gd, ed[i]);
      end
    end
  endtask

  task automatic test_busy_start();
    int spurious;
    set_cfg(5'd2, 5'd2, 8'd1, 8'd1, 3'd1, 26'h100, 26'h200);
    do_start();
    start = 1'b1;
    cfg_h = 5'd3;
    act_base = 26'h300;
    collect(0, 1'b1);
    tests++;
    if (timed_out || hs_addr.size() != 5 || hs_addr[0] !== 26'h100 || hs_addr[3] !== 26'h103) begin
      fails++; $display("FAIL busy_start_latched_cfg: got %0d reads expected 5 from 100", hs_addr.size());
    end
    spurious = 0;
    for (int i = 0; i < 10; i++) begin
      if (busy || rvalid || din_valid) spurious++;
      @(negedge clk);
    end
    tests++;
    if (spurious != 0) begin
      fails++; $display("FAIL start_with_done_ignored: got %0d active cycles expected 0", spurious);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    int idle_bad;
    bit reached;
    set_cfg(5'd2, 5'd2, 8'd1, 8'd1, 3'd1, 26'h100, 26'h200);
    do_start();
    pulses = 0; reached = 0;
    for (int c = 0; c < 200; c++) begin
      rready = 1'b1;
      if (din_valid) pulses++;
      if (pulses == 3) begin
        reached = 1;
        break;
      end
      @(negedge clk);
    end
    tests++;
    if (!reached) begin
      fails++; $display("FAIL rstmid_reach_gap: got %0d pulses expected 3", pulses);
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({rvalid, raddr, din_valid, din_data, busy, done, checksum} !== '0) begin
      fails++;
      $display("FAIL rstmid_async_clear: got rv=%0b ra=%0h dv=%0b dd=%0h busy=%0b done=%0b cs=%0h, expected all 0",
               rvalid, raddr, din_valid, din_data, busy, done, checksum);
    end
    @(negedge clk);
    rst = 1'b0;
    rready = 1'b0;
    idle_bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (busy || rvalid || din_valid || done) idle_bad++;
      @(negedge clk);
    end
    tests++;
    if (idle_bad != 0) begin
      fails++; $display("FAIL rstmid_no_resume: got %0d active cycles expected 0", idle_bad);
    end
    do_start();
    collect(0, 1'b0);
    tests++;
    if (timed_out || hs_addr.size() != 5 || hs_addr[0] !== 26'h100 || hs_addr[4] !== 26'h200) begin
      fails++; $display("FAIL rstmid_replay_addr: got %0d reads expected 5 from 100", hs_addr.size());
    end
    tests++;
    if (dv_data.size() != 6 || dv_data[0] !== 16'hFFFF || dv_data[5] !== 16'h0) begin
      fails++; $display("FAIL rstmid_replay_data: got %0d pulses expected 6", dv_data.size());
    end
    tests++;
    if (checksum !== c_CS_FULL) begin
      fails++; $display("FAIL rstmid_checksum: got %0h expected %0h", checksum, c_CS_FULL);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_zero_dims();
    test_wrap();
    test_busy_start();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
